// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, EX/MEM register and an optional
// iterative signed MULT/DIV unit with HI/LO, built when EX_MULDIV_EN is defined.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        ALUSrcE,
  input  logic        RegDstE,
  input  logic [3:0]  ALUControlE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic [15:0] ExtendE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic [4:0]  WriteRegE,
  output logic        StallE,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  WriteRegM
);

  logic [31:0] src_a, src_b, op_b, alu_res;
  logic        is_md;

  assign is_md     = (ALUControlE == 4'd12) || (ALUControlE == 4'd13);
  assign WriteRegE = RegDstE ? RdE : RtE;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUOutM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   src_b = ResultW;
      2'b10:   src_b = ALUOutM;
      default: src_b = RD2E;
    endcase
  end

  assign op_b = ALUSrcE ? {{16{ExtendE[15]}}, ExtendE} : src_b;

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic        is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum, rem_sh, rem_diff;
  logic [63:0] prod_signed;

  assign mag_a       = src_a[31] ? -src_a : src_a;
  assign mag_b       = src_b[31] ? -src_b : src_b;
  // acc holds {partial product high, multiplier} for MULT, {remainder, quotient} for DIV
  assign add_sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign rem_sh      = acc_q[63:31];
  assign rem_diff    = rem_sh - {1'b0, opnd_q};
  assign prod_signed = neg_lo_q ? -acc_q : acc_q;

  assign StallE = ((state_q == MD_IDLE) && is_md) || (state_q == MD_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    case (state_q)
      MD_IDLE: begin
        if (is_md) begin
          is_div_d = (ALUControlE == 4'd13);
          cnt_d    = '0;
          state_d  = MD_BUSY;
          if (ALUControlE == 4'd13) begin
            opnd_d   = mag_b;
            acc_d    = {32'd0, mag_a};
            // A zero divisor yields an all-ones quotient, so keep it unsigned
            neg_lo_d = (src_a[31] ^ src_b[31]) && (src_b != 32'd0);
            neg_hi_d = src_a[31];
          end else begin
            opnd_d   = mag_a;
            acc_d    = {32'd0, mag_b};
            neg_lo_d = src_a[31] ^ src_b[31];
            neg_hi_d = src_a[31] ^ src_b[31];
          end
        end
      end
      MD_BUSY: begin
        if (is_div_q) begin
          acc_d = rem_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                               : {rem_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {add_sum, acc_q[31:1]};
        end
        if (cnt_q == 5'd31) state_d = MD_DONE;
        else                cnt_d   = cnt_q + 5'd1;
      end
      MD_DONE: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_q[31:0]  : acc_q[31:0];
          hi_d = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
        end else begin
          hi_d = prod_signed[63:32];
          lo_d = prod_signed[31:0];
        end
        cnt_d   = '0;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end
`else
  assign StallE = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      4'd0:  alu_res = src_a + op_b;
      4'd1:  alu_res = src_a - op_b;
      4'd2:  alu_res = src_a & op_b;
      4'd3:  alu_res = src_a | op_b;
      4'd4:  alu_res = src_a ^ op_b;
      4'd5:  alu_res = ~(src_a | op_b);
      4'd6:  alu_res = {31'd0, $signed(src_a) < $signed(op_b)};
      4'd7:  alu_res = {31'd0, src_a < op_b};
      4'd8:  alu_res = op_b << src_a[4:0];
      4'd9:  alu_res = op_b >> src_a[4:0];
      4'd10: alu_res = $signed(op_b) >>> src_a[4:0];
      4'd11: alu_res = {op_b[15:0], 16'h0000};
`ifdef EX_MULDIV_EN
      4'd14: alu_res = hi_q;
      4'd15: alu_res = lo_q;
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || StallE) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else begin
      RegWriteM  <= RegWriteE && !is_md;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      ALUOutM    <= alu_res;
      WriteDataM <= src_b;
      WriteRegM  <= WriteRegE;
    end
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX register outputs and applies operand forwarding. It performs the ALU operation and runs an iterative signed multiply/divide unit with HI/LO registers. It drives the EX/MEM pipeline register, asserting `StallE` while a multi-cycle operation is in flight so the hazard unit holds F/D/E.

## Interface
Parameters:
- none; all datapath widths are fixed at 32 bits, register indices at 5 bits.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `ALUSrcE`, `RegDstE`  in  1 each  control bits from the ID/EX register.
- `ALUControlE`  in  4  operation code, listed under Operation.
- `RD1E`, `RD2E`  in  32  register-file operands.
- `RtE`, `RdE`  in  5  destination candidates.
- `ExtendE`  in  16  immediate; sign-extended to 32 bits.
- `ForwardAE`, `ForwardBE`  in  2  forwarding select: 00 = `RD1E`/`RD2E`, 01 = `ResultW`, 10 = `ALUOutM`, 11 = the same as 00.
- `ResultW`  in  32  writeback result.
- `WriteRegE`  out  5  combinational: `RegDstE ? RdE : RtE` (for the hazard unit).
- `StallE`  out  1  combinational; high while the mul/div unit is busy.
- `RegWriteM`, `MemtoRegM`, `MemWriteM`  out  1 each  registered control bits.
- `ALUOutM`  out  32  registered ALU result.
- `WriteDataM`  out  32  registered forwarded SrcB, taken before the immediate mux.
- `WriteRegM`  out  5  registered destination register.

## Operation
- Operand A is the forwarded A value. Operand B is the sign-extended `ExtendE` when `ALUSrcE=1`, otherwise the forwarded B value.
- ALUControlE codes:
  - 0 ADD, 1 SUB; both wrap modulo 2^32 and ignore overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU (unsigned); result is 0 or 1.
  - 8 SLL, 9 SRL, 10 SRA: B shifted by `A[4:0]`.
  - 11 LUI: `{B[15:0],16'h0}`.
  - 12 MULT, 13 DIV (signed), 14 MFHI, 15 MFLO.
- Mul/div FSM has three states: IDLE, BUSY, DONE.
  - IDLE with code 12 or 13: capture operand magnitudes and result signs, clear the 5-bit counter, go to BUSY.
  - BUSY: one shift-add (MULT) or restoring-subtract (DIV) step per cycle. At counter 31 go to DONE, otherwise increment the counter.
  - DONE: apply the signs and write HI/LO, then go to IDLE.
  - MULT results: HI = product[63:32], LO = product[31:0].
  - DIV results: LO = quotient, truncated toward zero. HI = remainder, which takes the sign of the dividend.
  - Divide by zero: HI = dividend, LO = 32'hFFFFFFFF; the operation still takes the full latency.
- `StallE` = (IDLE and code ∈ {12,13}) or BUSY.
- MFHI/MFLO while IDLE return HI/LO directly. No write-to-read bypass is needed because DONE precedes any later instruction's E cycle.
- EX/MEM update, every cycle:
  - `StallE=1`: load a bubble. All outputs become 0.
  - Otherwise: load the E-stage values.
  - Codes 12 and 13 always forward `RegWriteM=0` regardless of `RegWriteE`.

## Timing
- Single-cycle ops have 1-cycle latency: the result appears on `ALUOutM` after the edge following E.
- MULT/DIV hold `StallE` high for exactly 33 cycles (issue cycle plus 32 BUSY cycles). In the DONE cycle `StallE=0` and the instruction leaves E. HI/LO are valid from the next cycle.
- Reset values:
  - `RegWriteM`, `MemtoRegM`, `MemWriteM` = 0.
  - `ALUOutM`, `WriteDataM`, `WriteRegM` = 0.
  - HI = LO = 0.
  - FSM in IDLE with counter 0, so `StallE=0` once the E operand is not 12 or 13.
- `rst` asserted during BUSY aborts the operation: HI/LO stay 0 and no partial result is written.
- A bubble from `FlushE` (all-zero E inputs) computes ADD 0+0 with `RegWriteM=0`. This is harmless.

## Configuration
- `EX_MULDIV_EN` defined: mul/div FSM, HI/LO and `StallE` are built as described.
- `EX_MULDIV_EN` undefined:
  - No FSM and no HI/LO registers.
  - `StallE` is tied to 0.
  - Codes 12 and 13 pass as no-ops with `RegWriteM=0`.
  - Codes 14 and 15 yield `ALUOutM=0`.

## Test plan
- Reset, then ADD with A=32'h7FFFFFFF, B=1 → `ALUOutM`=32'h80000000 one cycle later; all M outputs were 0 during reset.
- Forwarding: `ForwardAE`=10 with `ALUOutM`=5, `ForwardBE`=01 with `ResultW`=3, SUB → `ALUOutM`=2. Also `ALUSrcE=1`, `ExtendE`=16'hFFFF, ADD with A=1 → 0.
- MULT −7×6, then MFLO/MFHI → `StallE` high 33 cycles, M receives bubbles throughout, MFLO=32'hFFFFFFD6, MFHI=32'hFFFFFFFF.
- DIV −7/2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIV 9/0 → LO=32'hFFFFFFFF, HI=9, still 33 stall cycles.
- Reset asserted at BUSY counter 10 → next cycle `StallE=0` and MFHI/MFLO return 0.
- With `EX_MULDIV_EN` undefined: MULT gives `StallE` never high and `RegWriteM=0`; MFLO gives `ALUOutM=0`.
